// File: rtl/vexbus_responder.sv
// Single-port memory responder arbitrating a VexRiscv-style iBus/dBus pair and a debugger
// onto one memory strobe bus, with one transaction in flight at a time.
module vexbus_responder #(
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [31:0] ADR_LIMIT  = 32'h0003_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cpu_en,
   input  logic        i_ibus_cmd_valid,
   output logic        o_ibus_cmd_ready,
   input  logic [31:0] i_ibus_cmd_pc,
   output logic        o_ibus_rsp_valid,
   output logic        o_ibus_rsp_error,
   output logic [31:0] o_ibus_rsp_inst,
   input  logic        i_dbus_cmd_valid,
   output logic        o_dbus_cmd_ready,
   input  logic        i_dbus_cmd_wr,
   input  logic [3:0]  i_dbus_cmd_mask,
   input  logic [31:0] i_dbus_cmd_address,
   input  logic [31:0] i_dbus_cmd_data,
   output logic        o_dbus_rsp_ready,
   output logic        o_dbus_rsp_error,
   output logic [31:0] o_dbus_rsp_data,
   input  logic        i_dbg_mem_op,
   input  logic        i_dbg_rw,
   input  logic [31:0] i_dbg_adr,
   input  logic [31:0] i_dbg_do,
   output logic        o_dbg_mem_rdy,
   output logic        o_mem_op,
   output logic [31:0] o_mem_adr,
   output logic [3:0]  o_mem_wren,
   output logic [31:0] o_mem_di,
   input  logic [31:0] i_mem_do
);
   // state      | meaning
   // S_IDLE     | accepting requests, grant decided combinationally
   // S_RD_WAIT  | counting down to the response strobe (tag says I, D or DBG)
   // S_DBG_DONE | one dead cycle so a held dbg_mem_op is not granted twice
   typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_DBG_DONE} state_t;
   typedef enum logic [1:0] {TAG_I, TAG_D, TAG_DBG} tag_t;

   localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

   state_t     r_state;
   tag_t       r_tag;
   logic [1:0] r_lat_cnt;
   logic       r_err;

   logic w_idle;
   logic w_grant_dbg;
   logic w_grant_d;
   logic w_grant_i;
   logic w_d_mapped;
   logic w_i_mapped;
   logic w_fire;

   // Reset gates grants and strobes in the reset cycle itself, so an in-flight response is dropped.
   assign w_idle      = (r_state == S_IDLE) && !i_reset;
   assign w_grant_dbg = w_idle && i_dbg_mem_op;
   assign w_grant_d   = w_idle && !i_dbg_mem_op && i_dbus_cmd_valid && i_cpu_en;
   assign w_grant_i   = w_idle && !i_dbg_mem_op && !(i_dbus_cmd_valid && i_cpu_en)
                        && i_ibus_cmd_valid && i_cpu_en;
   assign w_d_mapped  = i_dbus_cmd_address < ADR_LIMIT;
   assign w_i_mapped  = i_ibus_cmd_pc < ADR_LIMIT;
   assign w_fire      = (r_state == S_RD_WAIT) && (r_lat_cnt == 2'd0) && !i_reset;

   assign o_ibus_cmd_ready = w_grant_i;
   assign o_dbus_cmd_ready = w_grant_d;

   always_comb begin
      o_mem_op   = 1'b0;
      o_mem_adr  = 32'h0;
      o_mem_wren = 4'h0;
      o_mem_di   = 32'h0;
      if (w_grant_dbg) begin
         o_mem_op   = 1'b1;
         o_mem_adr  = i_dbg_adr;
         o_mem_wren = {4{~i_dbg_rw}};
         o_mem_di   = i_dbg_do;
      end else if (w_grant_d && w_d_mapped) begin
         o_mem_op  = 1'b1;
         o_mem_adr = i_dbus_cmd_address;
         if (i_dbus_cmd_wr) begin
            o_mem_wren = i_dbus_cmd_mask;
            o_mem_di   = i_dbus_cmd_data;
         end
      end else if (w_grant_i && w_i_mapped) begin
         o_mem_op  = 1'b1;
         o_mem_adr = i_ibus_cmd_pc;
      end
   end

   assign o_ibus_rsp_valid = w_fire && (r_tag == TAG_I);
   assign o_ibus_rsp_error = o_ibus_rsp_valid && r_err;
   assign o_ibus_rsp_inst  = (o_ibus_rsp_valid && !r_err) ? i_mem_do : 32'h0;
   assign o_dbus_rsp_ready = w_fire && (r_tag == TAG_D);
   assign o_dbus_rsp_error = o_dbus_rsp_ready && r_err;
   assign o_dbus_rsp_data  = (o_dbus_rsp_ready && !r_err) ? i_mem_do : 32'h0;
   assign o_dbg_mem_rdy    = w_fire && (r_tag == TAG_DBG);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_tag     <= TAG_I;
         r_lat_cnt <= 2'd0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_dbg) begin
                  // Debug writes complete one cycle after the strobe.
                  r_state   <= S_RD_WAIT;
                  r_tag     <= TAG_DBG;
                  r_lat_cnt <= i_dbg_rw ? LAT_LOAD : 2'd0;
                  r_err     <= 1'b0;
               end else if (w_grant_d && !i_dbus_cmd_wr) begin
                  r_state   <= S_RD_WAIT;
                  r_tag     <= TAG_D;
                  r_lat_cnt <= LAT_LOAD;
                  r_err     <= !w_d_mapped;
               end else if (w_grant_i) begin
                  r_state   <= S_RD_WAIT;
                  r_tag     <= TAG_I;
                  r_lat_cnt <= LAT_LOAD;
                  r_err     <= !w_i_mapped;
               end
            end
            S_RD_WAIT: begin
               if (r_lat_cnt == 2'd0) begin
                  r_state <= (r_tag == TAG_DBG) ? S_DBG_DONE : S_IDLE;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 2'd1;
               end
            end
            S_DBG_DONE: r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vexbus_responder.sv
// Bench for vexbus_responder: transaction-level reference predicts grants and responses,
// a separate monitor pops the scoreboard whenever a response strobe appears.
module tb_vexbus_responder;
   localparam int          LAT   = 3;
   localparam logic [31:0] LIMIT = 32'h0003_0000;

   typedef enum int {K_I, K_D, K_G} kind_e;
   typedef struct {
      kind_e       kind;
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Driven DUT inputs (updated 1 time unit after each rising edge)
   logic        rst = 1'b1, cpu_en = 1'b0;
   logic        iv = 1'b0, dv = 1'b0, dwr = 1'b0, gop = 1'b0, grw = 1'b0;
   logic [31:0] ipc = '0, dadr = '0, ddat = '0, gadr = '0, gdo = '0, mem_do = '0;
   logic [3:0]  dmask = '0;

   logic        ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_error;
   logic [31:0] ibus_rsp_inst;
   logic        dbus_cmd_ready, dbus_rsp_ready, dbus_rsp_error;
   logic [31:0] dbus_rsp_data;
   logic        dbg_mem_rdy, mem_op;
   logic [31:0] mem_adr, mem_di;
   logic [3:0]  mem_wren;

   vexbus_responder #(.RD_LATENCY(LAT), .ADR_LIMIT(LIMIT)) dut (
      .i_clk(clk), .i_reset(rst), .i_cpu_en(cpu_en),
      .i_ibus_cmd_valid(iv), .o_ibus_cmd_ready(ibus_cmd_ready), .i_ibus_cmd_pc(ipc),
      .o_ibus_rsp_valid(ibus_rsp_valid), .o_ibus_rsp_error(ibus_rsp_error),
      .o_ibus_rsp_inst(ibus_rsp_inst),
      .i_dbus_cmd_valid(dv), .o_dbus_cmd_ready(dbus_cmd_ready), .i_dbus_cmd_wr(dwr),
      .i_dbus_cmd_mask(dmask), .i_dbus_cmd_address(dadr), .i_dbus_cmd_data(ddat),
      .o_dbus_rsp_ready(dbus_rsp_ready), .o_dbus_rsp_error(dbus_rsp_error),
      .o_dbus_rsp_data(dbus_rsp_data),
      .i_dbg_mem_op(gop), .i_dbg_rw(grw), .i_dbg_adr(gadr), .i_dbg_do(gdo),
      .o_dbg_mem_rdy(dbg_mem_rdy),
      .o_mem_op(mem_op), .o_mem_adr(mem_adr), .o_mem_wren(mem_wren), .o_mem_di(mem_di),
      .i_mem_do(mem_do)
   );

   // Requester intents: a pending request stays until the reference grants it
   bit          p_i, p_d, p_g, p_dwr, p_grw;
   logic [31:0] p_ipc, p_dadr, p_ddat, p_gadr, p_gdo;
   logic [3:0]  p_dmask;
   logic        n_rst = 1'b1, n_en = 1'b1;

   int   cyc = 0;
   int   busy_until = 0;
   int   checks = 0, errors = 0;
   exp_t sb_q[$];

   logic [31:0] ref_mem [int unsigned];
   logic [31:0] env_mem [int unsigned];
   int          env_due = -1;
   logic [31:0] env_data;

   always @(posedge clk) cyc++;

   function automatic logic [31:0] seed_word(int unsigned w);
      return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(logic [31:0] a);
      int unsigned w = {2'b00, a[31:2]};
      return ref_mem.exists(w) ? ref_mem[w] : seed_word(w);
   endfunction

   function automatic logic [31:0] env_rd(logic [31:0] a);
      int unsigned w = {2'b00, a[31:2]};
      return env_mem.exists(w) ? env_mem[w] : seed_word(w);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] kind_strobe(kind_e k);
      case (k)
         K_I:     return 32'd4;
         K_D:     return 32'd2;
         default: return 32'd1;
      endcase
   endfunction

   // Reference: who is granted this cycle, what the bus shows, what response is owed
   always @(negedge clk) if (cyc > 0) begin : model
      logic        e_ir, e_dr, e_op, mapped;
      logic [31:0] e_adr, e_di;
      logic [3:0]  e_wren;
      exp_t        e;
      e_ir = 0; e_dr = 0; e_op = 0; e_adr = 0; e_di = 0; e_wren = 0; mapped = 0;
      if (rst) begin
         busy_until = cyc + 1;
         sb_q.delete();
      end else if (cyc >= busy_until) begin
         if (gop) begin
            e_op = 1; e_adr = gadr; e_wren = grw ? 4'h0 : 4'hF; e_di = gdo;
            e.kind = K_G; e.due = cyc + (grw ? LAT : 1); e.data = 0; e.err = 0;
            sb_q.push_back(e);
            busy_until = e.due + 2;
            if (!grw) ref_mem[{2'b00, gadr[31:2]}] = gdo;
            p_g = 0;
         end else if (dv && cpu_en) begin
            e_dr = 1; mapped = dadr < LIMIT;
            if (dwr) begin
               if (mapped) begin
                  e_op = 1; e_adr = dadr; e_wren = dmask; e_di = ddat;
                  ref_mem[{2'b00, dadr[31:2]}] = merge(ref_rd(dadr), ddat, dmask);
               end
               busy_until = cyc + 1;
            end else begin
               if (mapped) begin e_op = 1; e_adr = dadr; end
               e.kind = K_D; e.due = cyc + LAT; e.data = mapped ? ref_rd(dadr) : 32'h0;
               e.err = !mapped;
               sb_q.push_back(e);
               busy_until = cyc + LAT + 1;
            end
            p_d = 0;
         end else if (iv && cpu_en) begin
            e_ir = 1; mapped = ipc < LIMIT;
            if (mapped) begin e_op = 1; e_adr = ipc; end
            e.kind = K_I; e.due = cyc + LAT; e.data = mapped ? ref_rd(ipc) : 32'h0;
            e.err = !mapped;
            sb_q.push_back(e);
            busy_until = cyc + LAT + 1;
            p_i = 0;
         end
      end
      chk("ibus_cmd_ready", {31'b0, ibus_cmd_ready}, {31'b0, e_ir});
      chk("dbus_cmd_ready", {31'b0, dbus_cmd_ready}, {31'b0, e_dr});
      chk("mem_op", {31'b0, mem_op}, {31'b0, e_op});
      chk("mem_adr", mem_adr, e_adr);
      chk("mem_wren", {28'b0, mem_wren}, {28'b0, e_wren});
      chk("mem_di", mem_di, e_di);
      // Memory environment follows what actually appears on the bus
      if (mem_op) begin
         if (mem_wren == 4'h0) begin
            env_due = cyc + LAT; env_data = env_rd(mem_adr);
         end else begin
            env_mem[{2'b00, mem_adr[31:2]}] = merge(env_rd(mem_adr), mem_di, mem_wren);
         end
      end
   end

   // Monitor: every response strobe must match the oldest owed response
   always @(negedge clk) if (cyc > 0) begin : monitor
      logic [31:0] strobes;
      exp_t        e;
      strobes = {29'b0, ibus_rsp_valid, dbus_rsp_ready, dbg_mem_rdy};
      if (!ibus_rsp_valid) begin
         chk("ibus_inst_idle", ibus_rsp_inst, 32'h0);
         chk("ibus_err_idle", {31'b0, ibus_rsp_error}, 32'h0);
      end
      if (!dbus_rsp_ready) begin
         chk("dbus_data_idle", dbus_rsp_data, 32'h0);
         chk("dbus_err_idle", {31'b0, dbus_rsp_error}, 32'h0);
      end
      if (rst) begin
         chk("strobes_in_reset", strobes, 32'h0);
      end else if (strobes != 0) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", strobes, 32'h0);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_cycle", 32'(cyc), 32'(e.due));
            chk("rsp_kind", strobes, kind_strobe(e.kind));
            if (e.kind == K_I) begin
               chk("ibus_inst", ibus_rsp_inst, e.data);
               chk("ibus_err", {31'b0, ibus_rsp_error}, {31'b0, e.err});
            end else if (e.kind == K_D) begin
               chk("dbus_data", dbus_rsp_data, e.data);
               chk("dbus_err", {31'b0, dbus_rsp_error}, {31'b0, e.err});
            end
         end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
         e = sb_q.pop_front();
         chk("missing_rsp", strobes, kind_strobe(e.kind));
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         rst = n_rst; cpu_en = n_en;
         iv = p_i; ipc = p_ipc;
         dv = p_d; dwr = p_dwr; dmask = p_dmask; dadr = p_dadr; ddat = p_ddat;
         gop = p_g; grw = p_grw; gadr = p_gadr; gdo = p_gdo;
         mem_do = (env_due == cyc) ? env_data : $urandom();
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [3:0] w = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
         0, 1, 2: return {26'b0, w, 2'b00};
         3, 4, 5: return 32'h0001_0000 + {26'b0, w, 2'b00};
         6:       return 32'h0002_FFFC;
         7:       return LIMIT;
         default: return LIMIT + {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
   endfunction

   task automatic rand_stim();
      if (!p_i && $urandom_range(0, 3) == 0) begin
         p_i = 1; p_ipc = rand_addr();
      end
      if (!p_d && $urandom_range(0, 3) == 0) begin
         p_d = 1; p_dwr = 1'($urandom_range(0, 1)); p_dmask = 4'($urandom_range(1, 15));
         p_dadr = rand_addr(); p_ddat = $urandom();
      end
      if (!p_g && $urandom_range(0, 15) == 0) begin
         p_g = 1; p_grw = 1'($urandom_range(0, 1));
         p_gadr = {26'b0, 4'($urandom_range(0, 15)), 2'b00}; p_gdo = $urandom();
      end
      if ($urandom_range(0, 15) == 0) n_en = !n_en;
      n_rst = ($urandom_range(0, 199) == 0);
   endtask

   initial begin
      step(2);
      n_rst = 0;
      step(2);
      // Fetch of a known word at 0x20000
      ref_mem[32'h8000] = 32'h0007_2783; env_mem[32'h8000] = 32'h0007_2783;
      p_i = 1; p_ipc = 32'h0002_0000;
      step(6);
      // dBus and iBus together: dBus first
      p_d = 1; p_dwr = 0; p_dadr = 32'h0000_0100; p_dmask = 4'hF; p_ddat = 0;
      p_i = 1; p_ipc = 32'h0000_0104;
      step(10);
      // Debug read arriving while a dBus read is outstanding
      p_d = 1; p_dwr = 0; p_dadr = 32'h0001_0004;
      step(1);
      p_g = 1; p_grw = 1; p_gadr = 32'h0001_0004; p_gdo = 32'h1234_5678;
      step(12);
      // Masked write, then read it back
      p_d = 1; p_dwr = 1; p_dadr = 32'h0001_0000; p_ddat = 32'hDEAD_BEEF; p_dmask = 4'b0011;
      step(3);
      p_d = 1; p_dwr = 0; p_dadr = 32'h0001_0000;
      step(6);
      // Unmapped fetch
      p_i = 1; p_ipc = LIMIT;
      step(6);
      // Reset one cycle after a fetch grant abandons the response
      p_i = 1; p_ipc = 32'h0000_0040;
      step(1);
      n_rst = 1;
      step(1);
      n_rst = 0;
      step(8);
      // CPU disabled: only the debugger is served
      n_en = 0;
      p_i = 1; p_ipc = 32'h0000_0008;
      p_d = 1; p_dwr = 0; p_dadr = 32'h0000_000C;
      p_g = 1; p_grw = 0; p_gadr = 32'h0000_0008; p_gdo = 32'hCAFE_F00D;
      step(12);
      n_en = 1;
      step(12);
      for (int i = 0; i < 3000; i++) begin
         rand_stim();
         step(1);
      end
      n_rst = 0; n_en = 1;
      step(40);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vexbus_responder.md
VEXBUS_RESPONDER -- requirements
Module: vexbus_responder

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, giving the cycles from a memory read strobe to valid mem_do (legal range 1..3).
REQ-002 SHALL have parameter ADR_LIMIT, default 32'h0003_0000, the first unmapped byte address.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_en  in  1  CPU requests are granted only while high.
REQ-006 ibus_cmd_valid  in  1  instruction fetch request, held until accepted.
REQ-007 ibus_cmd_ready  out  1  fetch accepted this cycle.
REQ-008 ibus_cmd_pc  in  32  fetch byte address.
REQ-009 ibus_rsp_valid  out  1  one-cycle fetch response strobe.
REQ-010 ibus_rsp_error  out  1  fetch hit an unmapped address; valid with ibus_rsp_valid.
REQ-011 ibus_rsp_inst  out  32  fetched word.
REQ-012 dbus_cmd_valid  in  1  data request, held until accepted.
REQ-013 dbus_cmd_ready  out  1  data request accepted this cycle.
REQ-014 dbus_cmd_wr  in  1  1=write, 0=read.
REQ-015 dbus_cmd_mask  in  4  byte-lane write enables.
REQ-016 dbus_cmd_address  in  32  data byte address.
REQ-017 dbus_cmd_data  in  32  write data.
REQ-018 dbus_rsp_ready  out  1  one-cycle read response strobe.
REQ-019 dbus_rsp_error  out  1  read hit an unmapped address.
REQ-020 dbus_rsp_data  out  32  read word.
REQ-021 dbg_mem_op  in  1  debugger access request, held until dbg_mem_rdy.
REQ-022 dbg_rw  in  1  1=read, 0=write (all four lanes).
REQ-023 dbg_adr  in  32  debugger byte address.
REQ-024 dbg_do  in  32  debugger write data; read data returns via the shared mem_do bus.
REQ-025 dbg_mem_rdy  out  1  one-cycle debugger completion strobe.
REQ-026 mem_op  out  1  memory bus strobe.
REQ-027 mem_adr  out  32  memory byte address.
REQ-028 mem_wren  out  4  byte write enables; 0 means read.
REQ-029 mem_di  out  32  memory write data.
REQ-030 mem_do  in  32  memory read data, valid RD_LATENCY cycles after the strobe.

Function
REQ-031 FSM states SHALL be IDLE, RD_WAIT (tagged I/D/DBG) and DBG_DONE; at most one transaction is in flight.
REQ-032 In IDLE, the grant priority SHALL be dbg_mem_op > dbus_cmd_valid&cpu_en > ibus_cmd_valid&cpu_en, decided combinationally within the same cycle T.
REQ-033 On a CPU grant in cycle T: the matching cmd_ready=1 for exactly cycle T; mem_op=1 with the address, wren and data in T only, unless the address is >= ADR_LIMIT, in which case mem_op=0.
REQ-034 On a CPU read, the response strobe SHALL be at T+RD_LATENCY, with rsp_data=mem_do (or 0 plus error=1 if unmapped); then the FSM returns to IDLE.
REQ-035 On a dBus write, the FSM SHALL stay in IDLE with no response strobe, and mem_wren=dbus_cmd_mask; an unmapped write is accepted and dropped.
REQ-036 On a debug grant, mem_wren={4{~dbg_rw}}; dbg_mem_rdy SHALL pulse at T+RD_LATENCY for reads and at T+1 for writes.
REQ-037 DBG_DONE SHALL last one cycle after a dbg_mem_rdy strobe, so that a still-high dbg_mem_op is not regranted.
REQ-038 In any non-IDLE state: no grants, all cmd_ready=0, mem_op=0; pending requests wait.
REQ-039 When idle, mem_op, mem_adr, mem_wren and mem_di SHALL be 0; the response data outputs SHALL be 0 outside their strobe cycle.
REQ-040 When cpu_en falls mid-transaction, the in-flight transaction SHALL complete normally.

Reset
REQ-041 Reset SHALL force IDLE, clear the latency counter, drive all strobe, ready and error outputs to 0, and abandon an in-flight response without emitting it.

Verification
REQ-042 iBus fetch at 0x20000, RD_LATENCY=1, mem_do=0x00072783 -> ibus_cmd_ready at T, ibus_rsp_valid at T+1 with inst 0x00072783 and error 0.
REQ-043 dbus and ibus both valid in one cycle -> dbus granted at T, ibus_cmd_ready first at T+2 (after the dbus read response at T+1).
REQ-044 dbg read arriving during a dbus read RD_WAIT -> dbg waits; after the dbus response, dbg is granted and dbg_mem_rdy pulses exactly once.
REQ-045 dbus write 0xDEADBEEF, mask 4'b0011, to 0x10000 -> mem_op=1 and mem_wren=4'b0011 for one cycle, no dbus_rsp_ready.
REQ-046 ibus fetch at 0x00030000 -> mem_op stays 0; ibus_rsp_valid=1, error=1, inst=0.
REQ-047 reset asserted at T+1 with RD_LATENCY=3 -> no rsp strobe ever, next grant from IDLE; cpu_en=0 -> only dbg is served.
